// File: rtl/ghost_path_fsm.sv
// ghost_path_fsm: sequential next-step chooser for a ghost on a wall map.
// Checks the four neighbours one per clock (up, left, down, right), then picks a
// direction for chase (minimum Manhattan distance), flee (maximum distance) or
// frightened (LFSR start point, first legal cyclically). The reverse of the last move
// is never chosen while another legal move exists. With no other move, the ghost
// reverses. If the reverse is also blocked, stuck is raised.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   map                   wall bitmap, bit x+y*MAP_W, 1 = wall; stable while busy
//   start                 request, sampled only in IDLE
//   cur_x/cur_y           ghost position, latched on start
//   tgt_x/tgt_y           target position, latched on start
//   prev_dir              last move direction, latched on start
//   mode                  00 chase, 01 flee, 10 frightened, 11 chase
//   busy                  evaluation in progress
//   done                  one-cycle pulse when dir/stuck update
//   dir                   00 up, 01 down, 10 left, 11 right
//   stuck                 no legal move, reversal included
module ghost_path_fsm #(
    parameter int unsigned MAP_W  = 18,
    parameter int unsigned MAP_H  = 5,
    parameter int unsigned XW     = 5,
    parameter int unsigned YW     = 5,
    parameter bit          WRAP_X = 1'b0,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:MAP_W*MAP_H-1]   map,
    input  logic                     start,
    input  logic [XW-1:0]            cur_x,
    input  logic [YW-1:0]            cur_y,
    input  logic [XW-1:0]            tgt_x,
    input  logic [YW-1:0]            tgt_y,
    input  logic [1:0]               prev_dir,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dir,
    output logic                     stuck
);

    localparam int unsigned NCELL = MAP_W * MAP_H;
    localparam int unsigned IW    = $clog2(NCELL);
    localparam int unsigned DW    = XW + YW + 1;
    localparam logic [XW-1:0] X_MAX = XW'(MAP_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(MAP_H - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EVAL0   = 3'd1;
    localparam logic [2:0] S_EVAL3   = 3'd4;
    localparam logic [2:0] S_RESOLVE = 3'd5;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    // Evaluation-order index (0 up, 1 left, 2 down, 3 right) to direction code
    function automatic logic [1:0] ord2dir(input logic [1:0] k);
        logic [1:0] d;
        case (k)
            2'd0:    d = D_UP;
            2'd1:    d = D_LEFT;
            2'd2:    d = D_DOWN;
            default: d = D_RIGHT;
        endcase
        return d;
    endfunction

    logic [2:0]    state, state_n;
    logic [XW-1:0] cx, cx_n, tx, tx_n;
    logic [YW-1:0] cy, cy_n, ty, ty_n;
    logic [1:0]    pdir, pdir_n, mode_q, mode_n;
    logic [3:0]    legal, legal_n;
    logic          rev_ok, rev_ok_n;
    logic [1:0]    best_idx, best_idx_n;
    logic [DW-1:0] best_dist, best_dist_n;
    logic          have_best, have_best_n;
    logic          busy_n, done_n, stuck_n;
    logic [1:0]    dir_n;
    logic [7:0]    lfsr;

    // Candidate cell for the current evaluation step
    logic [1:0]    k;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic          cand_inb;
    logic [IW-1:0] cand_cell;
    logic          cand_open;
    logic          cand_rev;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [DW-1:0] cand_dist;
    logic          better;

    always_comb begin
        k        = 2'(state - S_EVAL0);
        cand_x   = cx;
        cand_y   = cy;
        cand_inb = 1'b0;
        case (k)
            2'd0: begin
                cand_y   = cy - YW'(1);
                cand_inb = (cy != '0);
            end
            2'd1: begin
                cand_x   = (cx == '0) ? X_MAX : cx - XW'(1);
                cand_inb = (cx != '0) || WRAP_X;
            end
            2'd2: begin
                cand_y   = cy + YW'(1);
                cand_inb = (cy != Y_MAX);
            end
            default: begin
                cand_x   = (cx == X_MAX) ? '0 : cx + XW'(1);
                cand_inb = (cx != X_MAX) || WRAP_X;
            end
        endcase
        // Out-of-bounds candidates never index the map
        cand_cell = cand_inb ? (IW'(cand_x) + IW'(cand_y) * IW'(MAP_W)) : '0;
        cand_open = cand_inb && !map[cand_cell];
        cand_rev  = (ord2dir(k) == (pdir ^ 2'b01));
        // Compare-then-subtract keeps the absolute difference unsigned-safe
        dx        = (cand_x >= tx) ? cand_x - tx : tx - cand_x;
        dy        = (cand_y >= ty) ? cand_y - ty : ty - cand_y;
        cand_dist = DW'(dx) + DW'(dy);
        better    = (mode_q == 2'b01) ? (cand_dist > best_dist) : (cand_dist < best_dist);
    end

    // Frightened pick: first legal candidate scanning cyclically from lfsr[1:0]
    logic [1:0] fr_pick;
    logic       fr_found;
    logic [1:0] fr_j;

    always_comb begin
        fr_pick  = lfsr[1:0];
        fr_found = 1'b0;
        fr_j     = '0;
        for (int i = 0; i < 4; i++) begin
            fr_j = lfsr[1:0] + 2'(i);
            if (!fr_found && legal[fr_j]) begin
                fr_pick  = fr_j;
                fr_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        cx_n        = cx;
        cy_n        = cy;
        tx_n        = tx;
        ty_n        = ty;
        pdir_n      = pdir;
        mode_n      = mode_q;
        legal_n     = legal;
        rev_ok_n    = rev_ok;
        best_idx_n  = best_idx;
        best_dist_n = best_dist;
        have_best_n = have_best;
        busy_n      = busy;
        done_n      = 1'b0;
        dir_n       = dir;
        stuck_n     = stuck;

        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    cx_n        = cur_x;
                    cy_n        = cur_y;
                    tx_n        = tgt_x;
                    ty_n        = tgt_y;
                    pdir_n      = prev_dir;
                    mode_n      = mode;
                    legal_n     = '0;
                    rev_ok_n    = 1'b0;
                    have_best_n = 1'b0;
                    busy_n      = 1'b1;
                    state_n     = S_EVAL0;
                end
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (cand_open) begin
                    if (cand_rev) begin
                        rev_ok_n = 1'b1;
                    end else begin
                        legal_n[k] = 1'b1;
                        // Strict comparison: ties keep the earlier candidate
                        if (!have_best || better) begin
                            best_idx_n  = k;
                            best_dist_n = cand_dist;
                            have_best_n = 1'b1;
                        end
                    end
                end
                state_n = (state == S_EVAL3) ? S_RESOLVE : state + 3'd1;
            end
            S_RESOLVE: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
                if (legal != '0) begin
                    dir_n   = (mode_q == 2'b10) ? ord2dir(fr_pick) : ord2dir(best_idx);
                    stuck_n = 1'b0;
                end else if (rev_ok) begin
                    dir_n   = pdir ^ 2'b01;
                    stuck_n = 1'b0;
                end else begin
                    dir_n   = pdir;
                    stuck_n = 1'b1;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; LFSR free-runs every clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            tx        <= '0;
            ty        <= '0;
            pdir      <= '0;
            mode_q    <= '0;
            legal     <= '0;
            rev_ok    <= 1'b0;
            best_idx  <= '0;
            best_dist <= '0;
            have_best <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir       <= 2'b00;
            stuck     <= 1'b0;
            lfsr      <= SEED;
        end else begin
            state     <= state_n;
            cx        <= cx_n;
            cy        <= cy_n;
            tx        <= tx_n;
            ty        <= ty_n;
            pdir      <= pdir_n;
            mode_q    <= mode_n;
            legal     <= legal_n;
            rev_ok    <= rev_ok_n;
            best_idx  <= best_idx_n;
            best_dist <= best_dist_n;
            have_best <= have_best_n;
            busy      <= busy_n;
            done      <= done_n;
            dir       <= dir_n;
            stuck     <= stuck_n;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule
